// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: deserialises 11-bit device-to-host frames and assembles
// standard 3-byte stream-mode packets into registered button/delta outputs.
// Receive-only; the PS/2 lines are never driven.
module ps2_mouse_rx #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       CLOCK_50,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic       packet_valid,
   output logic       button_left,
   output logic       button_right,
   output logic       button_middle,
   output logic [8:0] dx,
   output logic [8:0] dy,
   output logic       x_ovf,
   output logic       y_ovf,
   output logic       frame_err
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   typedef struct packed {
      logic [2:0] btn;   // {middle, right, left}
      logic [8:0] dx;
      logic [8:0] dy;
      logic       xo;
      logic       yo;
   } pkt_t;

   // synchroniser chain
   logic clk_s1, clk_s2, clk_s3, dat_s1, dat_s2;
   logic fall;

   // frame / packet state
   state_t        state, state_n;
   logic [2:0]    bit_cnt, bit_cnt_n;
   logic [7:0]    shreg, shreg_n;
   logic          par_ok, par_ok_n;
   logic [1:0]    idx, idx_n;
   logic [7:0]    byte0, byte0_n;
   logic [7:0]    byte1, byte1_n;
   logic [CW-1:0] wdog, wdog_n;
   pkt_t          pkt, pkt_n;
   logic          pv_n, err_n;
   logic          active, timeout;

   // Two-flop synchronisers plus a third clock flop for edge detection.
   // Reset to 1 (idle bus) so releasing reset never looks like a falling edge.
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         clk_s3 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         clk_s3 <= clk_s2;
         dat_s1 <= ps2_dat;
         dat_s2 <= dat_s1;
      end
   end

   assign fall = clk_s3 & ~clk_s2;

   // Watchdog only runs while something partial is held (mid-frame or mid-packet).
   assign active  = (state != IDLE) || (idx != 2'd0);
   assign timeout = active && !fall && (wdog >= TO_LAST);

   // State registers for the frame FSM, packet assembly, watchdog and outputs.
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         state        <= IDLE;
         bit_cnt      <= 3'd0;
         shreg        <= 8'h00;
         par_ok       <= 1'b0;
         idx          <= 2'd0;
         byte0        <= 8'h00;
         byte1        <= 8'h00;
         wdog         <= '0;
         pkt          <= '0;
         packet_valid <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         state        <= state_n;
         bit_cnt      <= bit_cnt_n;
         shreg        <= shreg_n;
         par_ok       <= par_ok_n;
         idx          <= idx_n;
         byte0        <= byte0_n;
         byte1        <= byte1_n;
         wdog         <= wdog_n;
         pkt          <= pkt_n;
         packet_valid <= pv_n;
         frame_err    <= err_n;
      end
   end

   // Next-state logic: everything advances on a PS/2 clock fall; otherwise the
   // watchdog may discard partial state with a single error pulse.
   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      par_ok_n  = par_ok;
      idx_n     = idx;
      byte0_n   = byte0;
      byte1_n   = byte1;
      pkt_n     = pkt;
      pv_n      = 1'b0;
      err_n     = 1'b0;
      wdog_n    = '0;

      if (fall) begin
         case (state)
            IDLE: begin
               if (!dat_s2) begin
                  state_n   = DATA;
                  bit_cnt_n = 3'd0;
               end else begin
                  // spurious fall with data high: not a start bit
                  err_n = 1'b1;
                  idx_n = 2'd0;
               end
            end
            DATA: begin
               shreg_n   = {dat_s2, shreg[7:1]};
               bit_cnt_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_n = PARITY;
            end
            PARITY: begin
               par_ok_n = (^shreg) ^ dat_s2;
               state_n  = STOP;
            end
            STOP: begin
               state_n = IDLE;
               if (dat_s2 && par_ok) begin
                  case (idx)
                     2'd0: begin
                        // byte 0 must carry the always-one sync bit
                        if (shreg[3]) begin
                           byte0_n = shreg;
                           idx_n   = 2'd1;
                        end
                     end
                     2'd1: begin
                        byte1_n = shreg;
                        idx_n   = 2'd2;
                     end
                     default: begin
                        pkt_n.btn = byte0[2:0];
                        pkt_n.dx  = {byte0[4], byte1};
                        pkt_n.dy  = {byte0[5], shreg};
                        pkt_n.xo  = byte0[6];
                        pkt_n.yo  = byte0[7];
                        pv_n      = 1'b1;
                        idx_n     = 2'd0;
                     end
                  endcase
               end else begin
                  err_n = 1'b1;
                  idx_n = 2'd0;
               end
            end
            default: state_n = IDLE;
         endcase
      end else if (timeout) begin
         state_n = IDLE;
         idx_n   = 2'd0;
         err_n   = 1'b1;
      end else if (active) begin
         wdog_n = (wdog == TO_LAST) ? wdog : wdog + CW'(1);
      end
   end

   assign button_left   = pkt.btn[0];
   assign button_right  = pkt.btn[1];
   assign button_middle = pkt.btn[2];
   assign dx            = pkt.dx;
   assign dy            = pkt.dy;
   assign x_ovf         = pkt.xo;
   assign y_ovf         = pkt.yo;

endmodule

// File: doc/ps2_mouse_rx.md
# ps2_mouse_rx

Receives raw PS/2 clock/data from the mouse and deserialises 11-bit device-to-host frames. Assembles the standard 3-byte stream-mode packet and emits one registered packet per `packet_valid` pulse: button states, 9-bit signed X/Y deltas and overflow flags. Sits directly upstream of the position binning / button logic that drives the `enable`/`clr`/`middle` outputs and the motion indication. Receive-only: never drives the PS/2 lines.

## Interface
- `TIMEOUT_CYCLES`, default 50000: idle `CLOCK_50` cycles (1 ms at 50 MHz) without a PS/2 clock falling edge before a partial frame or packet is discarded.
- `CLOCK_50  in  1`: system clock; all logic on its rising edge.
- `reset_n  in  1`: synchronous, active-low reset.
- `ps2_clk  in  1`: raw PS/2 clock, asynchronous.
- `ps2_dat  in  1`: raw PS/2 data, asynchronous.
- `packet_valid  out  1`: one-cycle pulse; the packet outputs below were updated in the same cycle.
- `button_left`, `button_right`, `button_middle  out  1 each`: byte0 bits 0, 1, 2.
- `dx  out  9`: signed X delta, `{byte0[4], byte1}`.
- `dy  out  9`: signed Y delta, `{byte0[5], byte2}`.
- `x_ovf`, `y_ovf  out  1 each`: byte0 bits 6, 7.
- `frame_err  out  1`: one-cycle pulse on bad start, parity or stop bit, or on a timeout that discards state.

## Operation
- **Synchroniser.** `ps2_clk` and `ps2_dat` each pass through 2 flops. A third flop on clk gives `fall = clk_s3 & ~clk_s2`. All sampling uses `dat_s2` on the `fall` cycle only.
- **Frame FSM.** States IDLE, DATA, PARITY, STOP. Each transition happens only on `fall`.
  - IDLE: sample start bit. 0 → DATA with bit counter 0. 1 → `frame_err`, stay in IDLE.
  - DATA: shift bits in LSB first. After the 8th bit → PARITY.
  - PARITY: check odd parity (XOR of 8 data bits and the parity bit must be 1) and record the result → STOP.
  - STOP: stop must be 1 and parity must be good, otherwise `frame_err`. Byte is accepted only if both hold. Always → IDLE.
- **Packet assembly.** Byte index 0..2.
  - Index 0: accept the byte only if bit3 = 1 (sync bit). Otherwise discard silently and keep index 0.
  - Any frame error resets index to 0; the byte is discarded.
  - On acceptance of byte 2, latch all outputs, pulse `packet_valid`, index → 0.
- **Hold.** Outputs hold between packets and are not changed by errors.
- **Watchdog.** Counter clears on every `fall` and saturates. It counts only while FSM ≠ IDLE or index ≠ 0.
  - On reaching `TIMEOUT_CYCLES`: FSM → IDLE, index → 0, one `frame_err` pulse, counter clears.
  - In IDLE with index 0 it stays at 0; no error.
- **Reset.** `reset_n` low at any clock edge:
  - FSM IDLE, index 0, counter 0.
  - All outputs 0, including `dx`/`dy` = 0 and the pulses.
  - Synchroniser flops set to 1 (idle bus), so no spurious `fall` on release.
  - Reset mid-frame or mid-packet discards everything; the next packet must start with a fresh start bit.

## Timing
- A raw `ps2_clk` fall sampled at rising edge k makes `fall` high during cycle k+1→k+2. The state update occurs at edge k+2.
- `packet_valid`, `frame_err` and the updated packet outputs are high/valid for exactly the one cycle after edge k+2 following the relevant stop-bit fall. Latency is 3 `CLOCK_50` edges from sampling of the raw edge.
- At most one `packet_valid` per 33 PS/2 clock falls. `packet_valid` and `frame_err` are never high in the same cycle.
- Timeout and `fall` in the same cycle: `fall` wins; the counter clears and no timeout fires.
- Consumer needs no handshake. It must capture the outputs on `packet_valid` or use the held values.

## Test plan
- **Normal packet.** Reset, then frames 0x29 (parity 0), 0x05 (parity 1), 0xFE (parity 0) at 12.5 kHz PS/2 clock → one `packet_valid` pulse; `button_left`=1, right/middle=0, `dx`=+5 (0x005), `dy`=−2 (0x1FE), `x_ovf`/`y_ovf`=0, `frame_err` never high.
- **Resync.** Frame 0x00 (bit3 clear), then the 3 frames above → byte 0x00 silently dropped; exactly one `packet_valid` with the values above.
- **Parity error.** 0x29 with parity bit 1, then 0x05, 0xFE → `frame_err` pulse after the first frame. 0x05 is rejected at index 0 (bit3=0); then 0xFE (bit3=1) is accepted as byte0; no `packet_valid` until two more frames arrive.
- **Timeout.** `TIMEOUT_CYCLES`=100. Send 0x29, 0x05, idle 150 cycles, then full packet 0x08, 0x00, 0x00 → one `frame_err` about 100 cycles after the last fall; one `packet_valid` with buttons 0, `dx`=`dy`=0.
- **Mid-packet reset.** Assert `reset_n`=0 for 1 cycle between byte1 and byte2 → outputs all 0 next cycle; the subsequent lone byte does not produce `packet_valid`; a following full packet does.
- **Stop-bit error / bad start.** Stop bit 0 → `frame_err`, no `packet_valid`. A glitch fall with `dat`=1 in IDLE → `frame_err`, FSM stays IDLE.
